// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits + odd parity + stop,
// check the device ack, with start and frame timeouts. Lines are open-drain (oe=1 pulls low).
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ      = 50000000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_MS = 15,
    parameter int FRAME_TIMEOUT_MS = 2
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] tx_err
);
    localparam int NI   = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
    localparam int NS   = CLK_FREQ_HZ / 1000 * START_TIMEOUT_MS;
    localparam int NF   = CLK_FREQ_HZ / 1000 * FRAME_TIMEOUT_MS;
    localparam int NMX1 = (NI > NS) ? NI : NS;
    localparam int NMAX = (NMX1 > NF) ? NMX1 : NF;
    localparam int TW   = $clog2(NMAX + 1);
    localparam logic [TW-1:0] NI_M1 = TW'(NI - 1);
    localparam logic [TW-1:0] NS_M1 = TW'(NS - 1);
    localparam logic [TW-1:0] NF_M1 = TW'(NF - 1);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, START, REQ, SHIFT, ACK, WAIT_IDLE, ABORT, DONE
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [3:0]      n_q, n_d;
    logic [9:0]      sh_q, sh_d;
    logic            doe_q, doe_d;
    logic [1:0]      err_q, err_d;
    logic            c_s1_q, c_s2_q, c_prev_q;
    logic            d_s1_q, d_s2_q, d_prev_q;
    logic            fall, idle, in_frame;

    // Synchronizers reset high so a released bus does not look like an edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            c_s1_q <= 1'b1; c_s2_q <= 1'b1; c_prev_q <= 1'b1;
            d_s1_q <= 1'b1; d_s2_q <= 1'b1; d_prev_q <= 1'b1;
        end else begin
            c_s1_q <= ps2_clk_i;  c_s2_q <= c_s1_q; c_prev_q <= c_s2_q;
            d_s1_q <= ps2_data_i; d_s2_q <= d_s1_q; d_prev_q <= d_s2_q;
        end
    end

    assign fall     = c_prev_q & ~c_s2_q;
    assign idle     = c_s2_q & c_prev_q & d_s2_q & d_prev_q;
    assign in_frame = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            doe_q   <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            doe_q   <= doe_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        n_d     = n_q;
        sh_d    = sh_q;
        doe_d   = doe_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                n_d   = '0;
                doe_d = 1'b0;
                if (tx_valid) begin
                    sh_d    = {1'b1, ~^tx_data, tx_data};
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmr_q == NI_M1) begin
                    tmr_d   = '0;
                    state_d = START;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            START: begin
                tmr_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                if (fall) begin
                    // First device fall puts D0 on the line; the frame timer counts this cycle.
                    doe_d   = ~sh_q[0];
                    sh_d    = {1'b0, sh_q[9:1]};
                    n_d     = 4'd1;
                    tmr_d   = TW'(1);
                    state_d = SHIFT;
                end else if (tmr_q == NS_M1) begin
                    err_d   = 2'b01;
                    state_d = ABORT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            SHIFT: begin
                tmr_d = tmr_q + 1'b1;
                if (fall) begin
                    doe_d = ~sh_q[0];
                    sh_d  = {1'b0, sh_q[9:1]};
                    n_d   = n_q + 4'd1;
                    if (n_q == 4'd9) state_d = ACK;
                end
            end
            ACK: begin
                tmr_d = tmr_q + 1'b1;
                if (fall) begin
                    if (!d_s2_q) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        err_d   = 2'b11;
                        state_d = ABORT;
                    end
                end
            end
            WAIT_IDLE: begin
                tmr_d = tmr_q + 1'b1;
                if (idle) begin
                    err_d   = 2'b00;
                    state_d = DONE;
                end
            end
            ABORT:   state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Frame timeout outranks whatever the frame states decided this cycle.
        if (in_frame && (tmr_q == NF_M1)) begin
            err_d   = 2'b10;
            state_d = ABORT;
        end
    end

    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == START);
    assign ps2_data_oe = (state_q == START) || (state_q == REQ) || ((state_q == SHIFT) && doe_q);
    assign tx_ready    = (state_q == IDLE);
    assign busy        = ~tx_ready;
    assign tx_done     = (state_q == DONE) || (state_q == ABORT);
    assign tx_err      = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model; clock scaled to 2 MHz
// so the 15 ms start timeout fits in a short run (all counts derive from CLK_HZ).
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int CLK_HZ = 2000000;
    localparam int NI     = CLK_HZ / 1000000 * 100;  // 200
    localparam int NS     = CLK_HZ / 1000 * 15;      // 30000
    localparam int NF     = CLK_HZ / 1000 * 2;       // 4000
    localparam int H      = CLK_HZ / 25000;          // half period of 12.5 kHz bus clock = 80

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, tx_done;
    logic [1:0] tx_err;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       pin_clk, pin_data;

    int checks = 0, failures = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, rel_cyc = 0, rise_cyc = 0, inh_cyc = 0, fall_cyc = 0;
    logic [1:0] last_err = 2'b00, done_oe = 2'b00;
    logic       ready_q = 1'b1, clkoe_q = 1'b0;
    logic [9:0] rx_bits;

    assign pin_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign pin_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk_i(pin_clk), .ps2_data_i(pin_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #250 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ready_q <= tx_ready;
        clkoe_q <= ps2_clk_oe;
        if (tx_ready && !ready_q) rise_cyc <= cyc;
        if (ps2_clk_oe && !clkoe_q) inh_cyc <= cyc;
        if (!ps2_clk_oe && clkoe_q) rel_cyc <= cyc;
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            last_err <= tx_err;
            done_oe  <= {ps2_clk_oe, ps2_data_oe};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_req(input int bound);
        for (int i = 0; i < bound && !(ps2_data_oe && !ps2_clk_oe); i++) @(negedge clk);
    endtask

    task automatic wait_done(input int d0, input int bound);
        for (int i = 0; i < bound && done_cnt == d0; i++) @(negedge clk);
        @(negedge clk);
        chk("done_seen", done_cnt, d0 + 1);
    endtask

    // Device: wait for request-to-send, then clock nclk pulses, sampling data on each rise.
    task automatic dev_frame(input int nclk, input logic ack);
        for (int i = 0; i < NI + 500 && !(pin_clk && !pin_data); i++) @(negedge clk);
        chk("rts", 32'(pin_clk & ~pin_data), 1);
        rx_bits = '0;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            if (k == 1) fall_cyc = cyc;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) rx_bits[k-1] = pin_data;
            if (k == 11) dev_data_low = 1'b0;
            repeat (H) @(negedge clk);
        end
    endtask

    initial begin
        int n, d0;
        logic any_oe;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_done_err", {29'd0, tx_done, tx_err}, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: async reset mid-REQ drops both lines at once, no tx_done
        send(8'hED);
        wait_req(NI + 50);
        repeat (10) @(negedge clk);
        chk("t1_in_req", {30'd0, ps2_clk_oe, ps2_data_oe}, 1);
        d0 = done_cnt;
        #10 clrn = 1'b0;
        #1;
        chk("t1_oe_async", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        chk("t1_ready", {30'd0, tx_ready, busy}, 2);
        chk("t1_no_done", done_cnt, d0);

        // 2: 0xED, inhibit length, start bit, frame bits, ack ok
        d0 = done_cnt;
        send(8'hED);
        chk("t2_ready_drop", 32'(tx_ready), 0);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < NI + 50) begin
            n++;
            @(negedge clk);
        end
        chk("t2_inhibit_len", n, NI);
        chk("t2_start_bit", {30'd0, ps2_clk_oe, ps2_data_oe}, 3);
        @(negedge clk);
        chk("t2_req", {30'd0, ps2_clk_oe, ps2_data_oe}, 1);
        dev_frame(11, 1'b1);
        chk("t2_bits", rx_bits, 10'h3ED);
        wait_done(d0, 500);
        chk("t2_err", last_err, 0);

        // 3: 0x01 has parity 0; tx_valid pulses while busy are ignored
        d0 = done_cnt;
        send(8'h01);
        repeat (50) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            tx_valid = 1'b1; tx_data = 8'hAA;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (30) @(negedge clk);
        end
        dev_frame(11, 1'b1);
        chk("t3_bits", rx_bits, 10'h201);
        chk("t3_parity", 32'(rx_bits[8]), 0);
        wait_done(d0, 500);
        chk("t3_err", last_err, 0);
        any_oe = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (ps2_clk_oe || ps2_data_oe) any_oe = 1'b1;
        end
        chk("t3_single_byte", 32'(any_oe), 0);

        // 4: device never clocks -> start timeout exactly NS cycles after clock release
        d0 = done_cnt;
        send(8'hFF);
        wait_req(NI + 50);
        wait_done(d0, NS + 100);
        chk("t4_err", last_err, 1);
        chk("t4_time", done_cyc - rel_cyc, NS);
        chk("t4_released", done_oe, 0);

        // 5a: no ack -> err 11
        d0 = done_cnt;
        send(8'h3C);
        dev_frame(11, 1'b0);
        wait_done(d0, 500);
        chk("t5_noack_err", last_err, 3);

        // 5b: clocking stops after 4 bits; abort NF cycles after the synced first fall (2-flop lag)
        d0 = done_cnt;
        send(8'h55);
        dev_frame(4, 1'b1);
        wait_done(d0, NF + 500);
        chk("t5_frame_err", last_err, 2);
        chk("t5_frame_time", done_cyc - fall_cyc, NF + 2);
        chk("t5_released", done_oe, 0);

        // 6: back-to-back with tx_valid held
        d0 = done_cnt;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        tx_data = 8'hF4;
        dev_frame(11, 1'b1);
        chk("t6_bits1", rx_bits, 10'h3FF);
        wait_done(d0, 500);
        chk("t6_err1", last_err, 0);
        repeat (4) @(negedge clk);
        tx_valid = 1'b0;
        chk("t6_ready_after_done", rise_cyc - done_cyc, 1);
        chk("t6_inhibit_after_ready", inh_cyc - rise_cyc, 1);
        dev_frame(11, 1'b1);
        chk("t6_bits2", rx_bits, 10'h2F4);
        wait_done(d0 + 1, 500);
        chk("t6_err2", last_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
